// File: rtl/updown_cnt_pkg.sv
// Shared types and helpers for the modulo-N up/down counter family.
// The state encoding and direction constants are fixed so that FSM-timeout blocks can decode them directly.
package updown_cnt_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } cnt_state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Out-of-range load values saturate to the top of the count range rather than wrapping.
   function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [63:0] modulus);
      if ({32'd0, value} >= modulus) begin
         return 32'(modulus - 64'd1);
      end
      return value;
   endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that completes a period.
// Instantiated by updown_mod_counter only when UPDOWN_CNT_PRESCALE_EN is defined.
module cnt_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic res,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] preCount;

   assign tick = en && (preCount == LAST);

   // Counts only enabled cycles; clr restarts the period so a load or clear gets a full interval.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         preCount <= '0;
      end else if (clr) begin
         preCount <= '0;
      end else if (en) begin
         if (preCount == LAST) begin
            preCount <= '0;
         end else begin
            preCount <= preCount + CW'(1);
         end
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised modulo-N up/down counter with clear, clamped load, terminal-count pulse and one-shot halt.
// Optional prescaler is enabled by defining UPDOWN_CNT_PRESCALE_EN.
module updown_mod_counter
   import updown_cnt_pkg::*;
#(
   parameter int     WIDTH     = 4,
   parameter longint MODULUS   = 16,
   parameter longint RESET_VAL = 0,
   parameter int     PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             one_shot,
   output logic [WIDTH-1:0] y,
   output logic             tc,
   output logic             done
);

   // Terminal value held as a full WIDTH-bit constant so MODULUS == 2**WIDTH needs no special case.
   localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Y = WIDTH'(RESET_VAL);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be 2..32");
   end
   if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS must be 2..2**WIDTH");
   end
   if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
      $error("updown_mod_counter: RESET_VAL must be below MODULUS");
   end
   if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $error("updown_mod_counter: PRESCALE must be 1..256");
   end

   cnt_state_t       state, nextState;
   logic [WIDTH-1:0] nextY;
   logic             nextTc;
   logic             nextDone;
   logic [WIDTH-1:0] loadClamped;
   logic             stepReq;
   logic             atTerm;

   assign loadClamped = WIDTH'(clamp_load(32'(load_val), 64'(MODULUS)));

`ifdef UPDOWN_CNT_PRESCALE_EN
   logic preTick;

   // Prescaler only advances on cycles that could otherwise count, and restarts on clear or load.
   cnt_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk (clk),
      .res (res),
      .en  (en && (state == RUN) && !clr && !load),
      .clr (clr || load),
      .tick(preTick)
   );

   assign stepReq = preTick;
`else
   assign stepReq = en;
`endif

   assign atTerm = (dir == DIR_UP) ? (y == TERM) : (y == '0);

   // Next-state and output decode: clr beats load beats a count step; otherwise everything holds.
   always_comb begin
      nextState = state;
      nextY     = y;
      nextTc    = 1'b0;
      nextDone  = done;
      if (clr) begin
         nextState = RUN;
         nextY     = '0;
         nextDone  = 1'b0;
      end else if (load) begin
         nextState = RUN;
         nextY     = loadClamped;
         nextDone  = 1'b0;
      end else if (stepReq && (state == RUN)) begin
         if (atTerm) begin
            nextTc = 1'b1;
            if (one_shot) begin
               nextState = HALT;
               nextDone  = 1'b1;
            end else begin
               nextY = (dir == DIR_DOWN) ? TERM : '0;
            end
         end else begin
            nextY = (dir == DIR_DOWN) ? (y - WIDTH'(1)) : (y + WIDTH'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state <= RUN;
         y     <= RST_Y;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= nextState;
         y     <= nextY;
         tc    <= nextTc;
         done  <= nextDone;
      end
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10) against a modular-arithmetic reference model.
// Directed test-plan sequences followed by randomized stimulus; prescaler period follows UPDOWN_CNT_PRESCALE_EN.
module tb_updown_mod_counter;

   localparam int W = 4;
   localparam int M = 10;
   localparam int RV = 0;
`ifdef UPDOWN_CNT_PRESCALE_EN
   localparam int P = 3;
`else
   localparam int P = 1;
`endif

   logic         clk = 1'b0;
   logic         res = 1'b0;
   logic         en = 1'b0;
   logic         dir = 1'b1;
   logic         clr = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         one_shot = 1'b0;
   logic [W-1:0] y;
   logic         tc;
   logic         done;

   int expY = RV;
   bit expTc = 1'b0;
   bit halted = 1'b0;
   int preCnt = 0;
   int checks = 0;
   int passes = 0;

   updown_mod_counter #(
      .WIDTH(W),
      .MODULUS(M),
      .RESET_VAL(RV),
      .PRESCALE(P)
   ) dut (
      .clk(clk),
      .res(res),
      .en(en),
      .dir(dir),
      .clr(clr),
      .load(load),
      .load_val(load_val),
      .one_shot(one_shot),
      .y(y),
      .tc(tc),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      expY   = RV;
      expTc  = 1'b0;
      halted = 1'b0;
      preCnt = 0;
   endtask

   task automatic checkOutput(input string tag);
      checks++;
      assert (y === W'(expY)) passes++;
      else $error("[TB] FAIL %s y: got %0d expected %0d", tag, y, expY);
      checks++;
      assert (tc === expTc) passes++;
      else $error("[TB] FAIL %s tc: got %0b expected %0b", tag, tc, expTc);
      checks++;
      assert (done === halted) passes++;
      else $error("[TB] FAIL %s done: got %0b expected %0b", tag, done, halted);
   endtask

   // Drives one cycle of inputs, advances the reference model across the edge, then checks 1ns later.
   task automatic applyStimulus(input bit iEn, input bit iDir, input bit iClr, input bit iLoad,
                                input int iVal, input bit iOs, input string tag);
      int nxt;
      en       = iEn;
      dir      = iDir;
      clr      = iClr;
      load     = iLoad;
      load_val = W'(iVal);
      one_shot = iOs;
      @(posedge clk);
      expTc = 1'b0;
      if (iClr) begin
         expY = 0;
         halted = 1'b0;
         preCnt = 0;
      end else if (iLoad) begin
         expY = (iVal >= M) ? M - 1 : iVal;
         halted = 1'b0;
         preCnt = 0;
      end else if (iEn && !halted) begin
         preCnt = (preCnt + 1) % P;
         if (preCnt == 0) begin
            nxt = iDir ? (expY + 1) % M : (expY + M - 1) % M;
            if ((iDir && nxt == 0) || (!iDir && nxt == M - 1)) begin
               expTc = 1'b1;
               if (iOs) halted = 1'b1;
               else expY = nxt;
            end else begin
               expY = nxt;
            end
         end
      end
      #1;
      checkOutput(tag);
   endtask

   initial begin
      modelReset();
      #10;
      checkOutput("reset");
      res = 1'b1;

      for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 0, 0, 0, "upWrap");

      applyStimulus(0, 1, 0, 1, 2, 0, "loadDown");
      for (int i = 0; i < 5 * P; i++) applyStimulus(1, 0, 0, 0, 0, 0, "downWrap");

      applyStimulus(0, 1, 0, 1, 7, 1, "loadOneShot");
      for (int i = 0; i < 5 * P; i++) applyStimulus(1, 1, 0, 0, 0, 1, "oneShot");
      applyStimulus(1, 0, 0, 0, 0, 0, "haltHoldDown");
      applyStimulus(1, 1, 0, 0, 0, 0, "haltHoldOsOff");
      applyStimulus(0, 1, 0, 1, 3, 1, "haltExitLoad");
      for (int i = 0; i < 2 * P; i++) applyStimulus(1, 1, 0, 0, 0, 1, "resume");

      applyStimulus(1, 1, 1, 1, 5, 0, "clrBeatsLoad");
      applyStimulus(1, 1, 0, 1, 15, 0, "loadClamp");
      applyStimulus(1, 0, 0, 0, 0, 0, "afterClamp");

      applyStimulus(0, 1, 0, 1, 8, 1, "loadNearTerm");
      for (int i = 0; i < 3 * P; i++) applyStimulus(1, 1, 0, 0, 0, 1, "toHalt");
      applyStimulus(1, 1, 0, 1, 6, 1, "loadSix");
      #3 res = 1'b0;
      #1 modelReset();
      checkOutput("asyncReset");
      #1 res = 1'b1;

      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0, 0, "enRun");
      for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0, 0, "enHold");
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 0, 0, "enResume");

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 4) != 0, $urandom % 2, ($urandom % 32) == 0,
                       ($urandom % 25) == 0, $urandom_range(0, 15), ($urandom % 3) == 0, "random");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
